// File: rtl/gray_seq_pkg.sv
// rtl/gray_seq_pkg.sv - shared state encoding and default width for the Gray sequencer
package gray_seq_pkg;

    localparam int DEFAULT_WRD_LEN = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/gray_conv.sv
// rtl/gray_conv.sv - combinational binary to reflected Gray code converter
module gray_conv
    import gray_seq_pkg::*;
#(
    parameter int wrd_len = DEFAULT_WRD_LEN
) (
    input  logic [wrd_len-1:0] bin,
    output logic [wrd_len-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_seq_ctrl.sv
// rtl/gray_seq_ctrl.sv - handshaked Gray/binary sequence generator; GRAY_SEQ_CHECK_EN adds a sticky adjacency checker
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int wrd_len = DEFAULT_WRD_LEN
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [wrd_len-1:0] start_val_i,
    input  logic               one_shot_i,
    input  logic               dir_i,
    input  logic               stop_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [wrd_len-1:0] bin_o,
    output logic [wrd_len-1:0] gray_o,
    output logic               wrap_o,
    output logic               done_o,
    output logic               err_o
);

    localparam logic [wrd_len-1:0] ALL_ONES = '1;

    state_e             state;
    state_e             state_nxt;
    logic [wrd_len-1:0] bin_q;
    logic [wrd_len-1:0] bin_nxt;
    logic [wrd_len-1:0] gray_q;
    logic [wrd_len-1:0] gray_nxt;
    logic [wrd_len-1:0] sweep_cnt;
    logic               one_shot_q;
    logic               wrap_q;
    logic               done_q;
    logic               hs;
    logic               load_en;
    logic               sweep_last;
    logic               step_en;
    logic               finish_en;

    assign hs         = valid_o && ready_i;
    assign load_en    = (state == IDLE) && start_i;
    // sweep_cnt counts steps taken, so all-ones marks the final word of the sweep
    assign sweep_last = one_shot_q && (&sweep_cnt);
    assign step_en    = (state == RUN) && hs && !stop_i && !sweep_last;
    assign finish_en  = (state == RUN) && hs && !stop_i && sweep_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_nxt = hs ? IDLE : DRAIN;
                end else if (finish_en) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_o = (state != IDLE);
        bin_o   = bin_q;
        gray_o  = gray_q;
        wrap_o  = wrap_q;
        done_o  = done_q;
    end

    always_comb begin
        bin_nxt = bin_q;
        if (load_en) begin
            bin_nxt = start_val_i;
        end else if (step_en) begin
            bin_nxt = dir_i ? (bin_q - wrd_len'(1)) : (bin_q + wrd_len'(1));
        end
    end

    gray_conv #(
        .wrd_len(wrd_len)
    ) u_gray_conv (
        .bin  (bin_nxt),
        .gray (gray_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_q      <= '0;
            gray_q     <= '0;
            sweep_cnt  <= '0;
            one_shot_q <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            bin_q  <= bin_nxt;
            gray_q <= gray_nxt;
            done_q <= finish_en;
            if (load_en) begin
                one_shot_q <= one_shot_i;
                sweep_cnt  <= '0;
                wrap_q     <= 1'b0;
            end else if (step_en) begin
                sweep_cnt <= sweep_cnt + wrd_len'(1);
                wrap_q    <= dir_i ? (bin_q == '0) : (bin_q == ALL_ONES);
            end
        end
    end

`ifdef GRAY_SEQ_CHECK_EN
    logic [wrd_len-1:0] gray_diff;
    logic               err_q;

    // exactly one bit set: non-zero and clearing the lowest set bit leaves zero
    assign gray_diff = gray_nxt ^ gray_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (step_en &&
                     ((gray_diff == '0) || ((gray_diff & (gray_diff - wrd_len'(1))) != '0))) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: doc/gray_seq_ctrl.md
GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

Interface
REQ-001 SHALL have parameter wrd_len, default 5, code word width in bits (2..16).
REQ-002 SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port start_i, input, 1, start request; honoured only in IDLE.
REQ-005 SHALL have port start_val_i, input, wrd_len, first binary value, sampled with start_i.
REQ-006 SHALL have port one_shot_i, input, 1, 1 = single sweep of 2**wrd_len words; sampled with start_i.
REQ-007 SHALL have port dir_i, input, 1, 0 = increment, 1 = decrement; sampled on each handshake.
REQ-008 SHALL have port stop_i, input, 1, stop request.
REQ-009 SHALL have port ready_i, input, 1, consumer ready.
REQ-010 SHALL have port valid_o, output, 1, gray_o/bin_o hold a valid word.
REQ-011 SHALL have port bin_o, output, wrd_len, current binary count.
REQ-012 SHALL have port gray_o, output, wrd_len, Gray code of bin_o: bin_o ^ (bin_o >> 1).
REQ-013 SHALL have port wrap_o, output, 1, high while the presented word was reached by wrap-around.
REQ-014 SHALL have port done_o, output, 1, one-cycle pulse when a one-shot sweep completes.
REQ-015 SHALL have port err_o, output, 1, sticky Gray-adjacency error (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN; handshake = valid_o && ready_i.
REQ-017 SHALL, in IDLE with start_i=1, load bin_o=start_val_i, gray_o=gray(start_val_i), valid_o=1 on the next edge and enter RUN (1-cycle latency).
REQ-018 SHALL, in RUN on handshake, step bin_o by +1 or -1 (per dir_i) modulo 2**wrd_len and update gray_o on the same edge.
REQ-019 SHALL hold bin_o, gray_o, valid_o, wrap_o stable while valid_o=1 and ready_i=0.
REQ-020 SHALL set wrap_o=1 with a word produced by stepping all-ones->0 (up) or 0->all-ones (down); wrap_o=0 with every other word.
REQ-021 SHALL, in one-shot mode, count handshakes; on the 2**wrd_len-th handshake go IDLE, drop valid_o, pulse done_o for one cycle.
REQ-022 SHALL, on stop_i=1 in RUN coinciding with a handshake, go IDLE with valid_o=0 next cycle.
REQ-023 SHALL, on stop_i=1 in RUN without a handshake, go DRAIN, keeping the current word valid; on its handshake go IDLE with valid_o=0.
REQ-024 SHALL ignore start_i outside IDLE and stop_i in IDLE/DRAIN; stop has priority over one-shot completion (no done_o).
REQ-025 SHALL never present an out-of-range or skipped word; successive accepted words differ by exactly one in bin_o.

Reset
REQ-026 SHALL, on rst_ni=0 at any time, immediately force IDLE, valid_o=0, bin_o=0, gray_o=0, wrap_o=0, done_o=0, err_o=0 and clear the sweep counter.
REQ-027 SHALL remain in IDLE after rst_ni deasserts until start_i is seen.

Configuration
REQ-028 SHALL, with macro GRAY_SEQ_CHECK_EN defined, compare each new gray_o against the previously accepted gray_o and set err_o (sticky until reset) if the Hamming distance is not exactly 1 (start word excluded).
REQ-029 SHALL, without GRAY_SEQ_CHECK_EN, tie err_o to 0 and contain no checker logic.

Structure
REQ-030 SHALL place FSM state encoding (IDLE, RUN, DRAIN) and the default width constant in shared package gray_seq_pkg.
REQ-031 SHALL instantiate the team's combinational gray_conv sub-module (parameter wrd_len) on the next-count value; no duplicate conversion logic.

Verification
REQ-032 SHALL check: reset, start_i with start_val_i=5'd0, ready_i=1, dir_i=0 -> gray_o sequence 00000,00001,00011,00010,00110 on consecutive cycles.
REQ-033 SHALL check: start_val_i=5'd31, dir_i=0, ready_i=1 -> second word bin_o=0, gray_o=00000, wrap_o=1 for that word only.
REQ-034 SHALL check: ready_i=0 for 4 cycles mid-run at bin_o=7 -> bin_o=7, gray_o=00100 held all 4 cycles, valid_o=1.
REQ-035 SHALL check: one_shot_i=1, start_val_i=3, ready_i=1 -> exactly 32 handshakes, last word bin_o=2, then done_o single pulse, valid_o=0.
REQ-036 SHALL check: stop_i with ready_i=0 at bin_o=9 -> DRAIN holds 9; ready_i=1 -> one handshake, then valid_o=0, no done_o.
REQ-037 SHALL check: rst_ni pulsed low mid-run -> valid_o, bin_o, gray_o=0 asynchronously; with GRAY_SEQ_CHECK_EN, err_o stays 0 across a full up/down sweep.
